// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-high segment
// table (bit6=g .. bit0=a), the nibble decoder function and digit-count limits.
package seg7_pkg;

  localparam int MIN_DIGITS = 2;
  localparam int MAX_DIGITS = 8;

  // Entry h sits at [h]; hex 0-F with A, b, C, d, E, F glyphs.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return SEG_TABLE[h];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side data/strobe inputs and board-side segment/digit outputs of the
// scan driver, bundled so the counter core and board glue share one port.
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp;
  logic                  load;
  logic                  enable;
  logic [6:0]            seg;
  logic                  seg_dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_done;

  modport master (
    output value, dp, load, enable,
    input  seg, seg_dp, an, frame_done
  );

  modport slave (
    input  value, dp, load, enable,
    output seg, seg_dp, an, frame_done
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high seven-segment pattern (bit6=g .. bit0=a).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(nib);
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver: prescaled digit scan, double-buffered
// value capture applied only at frame wrap, leading-zero blanking, registered pins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input logic clk,
  input logic rst,
  seg7_scan_driver_if.slave bus
);
  localparam int IDX_W = (N_DIGITS > MIN_DIGITS) ? $clog2(N_DIGITS) : 1;
  localparam int PW    = $clog2(SCAN_DIV);
  localparam int VW    = 4 * N_DIGITS;

  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW  ? {N_DIGITS{1'b1}} : '0;
  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                DP_OFF  = SEG_ACTIVE_LOW;

  logic [PW-1:0]       presc;
  logic [IDX_W-1:0]    idx;
  logic [VW-1:0]       staging_val, shadow_val;
  logic [N_DIGITS-1:0] staging_dp, shadow_dp;
  logic                pending;

  logic                tc, wrap;
  logic [N_DIGITS-1:0] lz;
  logic [3:0]          nib;
  logic [6:0]          dec_seg;
  logic                cur_blank, cur_dp, show;
  logic [N_DIGITS-1:0] an_hi;
  logic [6:0]          seg_hi;
  logic                dp_hi;

  logic [N_DIGITS-1:0] an_q;
  logic [6:0]          seg_q;
  logic                dp_q, fd_q;

  assign tc   = (presc == PW'(SCAN_DIV - 1));
  assign wrap = tc && (idx == IDX_W'(N_DIGITS - 1));

  // Scan engine: prescaler plus digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc) begin
      presc <= '0;
      idx   <= wrap ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Staging takes every load; shadow only changes at a wrap so a frame is never
  // a mix of old and new digits. A load in the wrap cycle waits for the next wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging_val <= '0;
      staging_dp  <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
    end else begin
      if (wrap && pending) begin
        shadow_val <= staging_val;
        shadow_dp  <= staging_dp;
      end
      if (bus.load) begin
        staging_val <= bus.value;
        staging_dp  <= bus.dp;
        pending     <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // lz[k]: nibbles k..top are all zero; digit 0 is always shown.
  always_comb begin
    lz = '0;
    if (BLANK_LZ) begin
      lz[N_DIGITS-1] = (shadow_val[VW-4 +: 4] == 4'h0);
      for (int k = N_DIGITS - 2; k >= 1; k--)
        lz[k] = lz[k+1] && (shadow_val[4*k +: 4] == 4'h0);
    end
  end

  assign nib = shadow_val[4*idx +: 4];

  seg7_hex_decode u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  assign cur_blank = lz[idx];
  assign cur_dp    = shadow_dp[idx];
  assign show      = bus.enable && !tc;

  // A blanked digit with its dp requested still has its common line driven.
  always_comb begin
    an_hi  = '0;
    seg_hi = '0;
    dp_hi  = 1'b0;
    if (show) begin
      if (!cur_blank || cur_dp) an_hi = N_DIGITS'(1) << idx;
      if (!cur_blank)           seg_hi = dec_seg;
      dp_hi = cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
      fd_q  <= 1'b0;
    end else begin
      an_q  <= AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
      seg_q <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_q  <= SEG_ACTIVE_LOW ? ~dp_hi  : dp_hi;
      fd_q  <= wrap;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.seg_dp     = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scenarios followed by random loads/enable/reset, every cycle checked
// against a frame-arithmetic reference model of the 4-digit active-low display.
module tb_seg7_scan_driver;
  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int FRAME = N * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: cycles since reset, staged and displayed words.
  int         cnt;
  logic [15:0] stg_v, shd_v;
  logic [3:0]  stg_dp, shd_dp;
  bit          pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [6:0]  glyph [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit l, input logic [15:0] v,
                     input logic [3:0] d, input bit en);
    int phase, dig;
    bit tc, wrap, blank, dpq;
    logic [3:0] nb;
    rst = r; bus.load = l; bus.value = v; bus.dp = d; bus.enable = en;
    if (r) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
      cnt = 0; stg_v = '0; stg_dp = '0; shd_v = '0; shd_dp = '0; pend = 0;
    end else begin
      phase = cnt % FRAME;
      dig   = phase / SD;
      tc    = (phase % SD) == SD - 1;
      wrap  = (phase == FRAME - 1);
      e_fd  = wrap;
      nb    = 4'((shd_v >> (4 * dig)) & 16'hF);
      blank = (dig != 0) && ((shd_v >> (4 * dig)) == 16'h0);
      dpq   = shd_dp[dig];
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (en && !tc) begin
        e_dp = ~dpq;
        if (!blank || dpq) e_an = ~(4'b0001 << dig);
        if (!blank) e_seg = ~glyph[nb];
      end
      if (wrap && pend) begin shd_v = stg_v; shd_dp = stg_dp; pend = 0; end
      if (l) begin stg_v = v; stg_dp = d; pend = 1; end
      cnt++;
    end
    @(posedge clk);
    #1;
    chk("an", 32'(bus.an), 32'(e_an));
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("seg_dp", 32'(bus.seg_dp), 32'(e_dp));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, en);
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.enable = 1'b1;

    cyc(1, 0, '0, '0, 1);
    cyc(1, 0, '0, '0, 1);
    cyc(0, 1, 16'h0123, 4'b0000, 1);
    idle(2 * FRAME + 3, 1);
    cyc(0, 1, 16'h0000, 4'b0100, 1);
    idle(2 * FRAME, 1);
    cyc(0, 1, 16'hBEEF, 4'b0000, 1);
    idle(3 * FRAME, 1);
    idle(5, 1);
    cyc(0, 1, 16'h1111, 4'b0000, 1);
    idle(1, 1);
    cyc(0, 1, 16'h2222, 4'b0000, 1);
    idle(2 * FRAME, 1);
    idle(FRAME, 0);
    idle(FRAME, 1);
    while ((cnt % FRAME) != 2 * SD + 1) idle(1, 1);
    cyc(1, 0, '0, '0, 1);
    idle(FRAME + 2, 1);

    // Randomized phase: loads biased towards leading zeros, enable dropouts, rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] v;
      bit l, en, r;
      v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      l  = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 499) == 0);
      cyc(r, l, v, 4'($urandom), en);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for the 0–9999 counter board and later multi-digit designs. Takes a packed hex/BCD word plus per-digit decimal points, time-multiplexes N common-anode/cathode digits, decodes each nibble to segments and blanks leading zeros. Sits between the counter core and the board pins, replacing one static decoder per digit with a single shared decoder and a scan engine.

## Interface
- N_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 50000, clk cycles each digit is driven (≥ 2)
- SEG_ACTIVE_LOW, 1, 1: segment/dp outputs active-low
- AN_ACTIVE_LOW, 1, 1: digit-enable outputs active-low
- BLANK_LZ, 1, 1: leading-zero blanking enabled

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  4*N_DIGITS  packed nibbles; digit 0 = value[3:0] (least significant)
- dp  in  N_DIGITS  decimal point request per digit
- load  in  1  single-cycle strobe: capture value/dp into staging
- enable  in  1  0: all digits dark, scan keeps running
- seg  out  7  segments, bit order g..a (bit6=g, bit0=a)
- seg_dp  out  1  decimal point segment
- an  out  N_DIGITS  one-hot digit enable
- frame_done  out  1  one-cycle pulse when scan wraps from last digit to digit 0

## Operation
- Prescaler counts 0..SCAN_DIV-1; at terminal count digit index advances; index wraps N_DIGITS-1 → 0.
- frame_done asserts for the cycle in which the index wraps.
- Two-stage capture: load writes value/dp into staging and sets pending. At a wrap, if pending, shadow ← staging, pending ← 0. Display always reads shadow, so no frame ever shows mixed old/new digits.
- Multiple loads before a wrap: last wins. load in the wrap cycle: goes to staging, pending stays 1, applied at next wrap.
- Decode (active-high, hex 0–F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (A, b, C, d, E, F). Inverted when SEG_ACTIVE_LOW.
- Leading-zero blanking (BLANK_LZ=1): digit k blanked if nibbles k..N_DIGITS-1 of shadow are all 0, except digit 0, which is never blanked. Blanked digit: segments off; its dp still driven if requested.
- Blanked or disabled: an bit inactive, seg/seg_dp off.
- Dead time: during the terminal-count cycle of each digit all an outputs are inactive (anti-ghosting).

## Timing
- All outputs registered; an/seg/seg_dp reflect index/prescaler state of the previous cycle.
- Reset values: an all inactive, seg all off, seg_dp off, frame_done 0; prescaler 0, index 0, staging/shadow 0, pending 0.
- First digit 0 drive appears 1 cycle after rst deasserts (enable=1).
- Each digit lit SCAN_DIV-1 cycles, dark 1 cycle; frame period N_DIGITS*SCAN_DIV cycles.
- load → visible: at the next wrap, +1 cycle register latency; worst case N_DIGITS*SCAN_DIV+1 cycles.
- rst mid-frame: all state to reset values on the next edge; pending load discarded.
- enable change takes effect on outputs 1 cycle later; scan phase unaffected.

## Structure
- Package seg7_pkg: 16-entry segment constant table (active-high), function hex_to_seg, digit-count limits.
- Sub-module seg7_hex_decode: combinational nibble → 7-bit active-high pattern, instantiated once on the muxed nibble.
- Top holds prescaler, index, staging/shadow/pending, LZ blanking mask, output polarity and registers.

## Test plan
- N_DIGITS=4, SCAN_DIV=4, load value=16'h0123 then wait one frame → digit0 seg=~4F, digit1 ~5B, digit2 ~06, digit3 blanked (an[3] never low).
- value=16'h0000, dp=4'b0100 → only digit0 shows ~3F; digit2 an low with seg=7F (off), seg_dp=0.
- value=16'hBEEF, BLANK_LZ=1 → digits 0..3 show ~71, ~79, ~79, ~7C; frame_done every 16 cycles, 1 cycle wide.
- load 16'h1111 mid-frame then 16'h2222 two cycles later → current frame unchanged, next frame all digits ~5B.
- enable=0 for one frame → an=4'b1111 throughout, frame_done still pulses at period 16.
- rst asserted during digit 2 → next cycle an=4'b1111, seg=7F, frame_done=0; shadow reads 0 after release (digit0 shows ~3F).
